ds1302_slave_model: RTL



---
 rtl/ds1302_slave_model.sv | 263 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/ds1302_slave_model.sv
// ds1302_slave_model: responder-side emulation of the DS1302 3-wire RTC.
// Holds sec/min/hour/date/month/day/year/WP, advances sec/min/hour from an
// internal prescaler and answers CE/SCLK/IO transactions.
// Optional clock burst on address 31 is compiled in with DS1302_BURST_EN.
// Handshake: the initiator owns CE and SCLK. IO is sampled on a synchronized
// SCLK rise and driven on a synchronized SCLK fall, only while io_oe is set;
// CE low at any time aborts the transaction and discards a partial byte.
module ds1302_slave_model #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic       ds1302_clk,
  input  logic       ds1302_rst,
  input  logic       ds1302_ce,
  input  logic       ds1302_sclk,
  inout  wire        ds1302_io,
  output logic [7:0] cur_second,
  output logic [7:0] cur_minute,
  output logic [7:0] cur_hour,
  output logic [7:0] cur_date,
  output logic [7:0] cur_month,
  output logic [7:0] cur_week,
  output logic [7:0] cur_year,
  output logic       wr_commit,
  output logic       sec_tick,
  output logic       io_oe_o,
  output logic [2:0] dbg_state_o
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_TOP = PW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CMD    = 3'd1,
    S_WDATA  = 3'd2,
    S_RDATA  = 3'd3,
    S_IGNORE = 3'd4
  } state_t;

  // Synchronizers and edge detection
  logic [1:0] ce_sync_q, sclk_sync_q, io_sync_q;
  logic       sclk_prev_q;
  logic       ce_s, sclk_s, io_s, sclk_rise, sclk_fall;

  // Clock registers
  logic [7:0] sec_q, min_q, hour_q, date_q, month_q, week_q, year_q;
  logic       wp_q;
  logic [PW-1:0] presc_q;

  // Transaction state
  state_t     state_q;
  logic [5:0] cnt_q;
  logic [7:0] shift_q;
  logic [4:0] addr_q;
  logic       ram_q, burst_q, wp_lat_q;
  logic [63:0] rd_buf_q;
  logic [5:0] rd_last_q;
  logic       rd_done_q;
  logic       io_oe_q, io_out_q;
  logic       wr_commit_q, sec_tick_q;

  // Combinational helpers
  logic [7:0]  rx_byte;
  logic        is_burst;
  logic [7:0]  single_rd;
  logic [63:0] rd_snap;
  logic        wr_en;
  logic [2:0]  wr_idx;
  logic        tick_fire;
  logic [7:0]  sec_step, min_step;
  logic [5:0]  hour_inc;

  assign ce_s      = ce_sync_q[1];
  assign sclk_s    = sclk_sync_q[1];
  assign io_s      = io_sync_q[1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign rx_byte   = {io_s, shift_q[7:1]};

  assign ds1302_io   = io_oe_q ? io_out_q : 1'bz;
  assign cur_second  = sec_q;
  assign cur_minute  = min_q;
  assign cur_hour    = hour_q;
  assign cur_date    = date_q;
  assign cur_month   = month_q;
  assign cur_week    = week_q;
  assign cur_year    = year_q;
  assign wr_commit   = wr_commit_q;
  assign sec_tick    = sec_tick_q;
  assign io_oe_o     = io_oe_q;
  assign dbg_state_o = state_q;

`ifdef DS1302_BURST_EN
  assign is_burst = (rx_byte[6:1] == 6'b011111);
`else
  assign is_burst = 1'b0;
`endif

  // One BCD step with wrap: result bit7 flags the wrap (carry out)
  function automatic logic [7:0] bcd_step(input logic [6:0] v, input logic [6:0] top);
    logic [7:0] r;
    if (v == top)              r = 8'h80;
    else if (v[3:0] == 4'd9)   r = {1'b0, v[6:4] + 3'd1, 4'd0};
    else                       r = {1'b0, v + 7'd1};
    return r;
  endfunction

  // Bring the asynchronous initiator lines into the ds1302_clk domain
  always_ff @(posedge ds1302_clk) begin
    if (ds1302_rst) begin
      ce_sync_q   <= 2'b00;
      sclk_sync_q <= 2'b00;
      io_sync_q   <= 2'b00;
      sclk_prev_q <= 1'b0;
    end else begin
      ce_sync_q   <= {ce_sync_q[0], ds1302_ce};
      sclk_sync_q <= {sclk_sync_q[0], ds1302_sclk};
      io_sync_q   <= {io_sync_q[0], ds1302_io};
      sclk_prev_q <= sclk_sync_q[1];
    end
  end

  // Timekeeping increments; hour counts 00..23 on its low six bits only
  always_comb begin
    tick_fire = !sec_q[7] && (presc_q == PRESC_TOP);
    sec_step  = bcd_step(sec_q[6:0], 7'h59);
    min_step  = bcd_step(min_q[6:0], 7'h59);
    if (hour_q[5:0] == 6'h23)      hour_inc = 6'h00;
    else if (hour_q[3:0] == 4'd9)  hour_inc = {hour_q[5:4] + 2'd1, 4'd0};
    else                           hour_inc = hour_q[5:0] + 6'd1;
  end

  // Read snapshot taken at command decode (single byte or the whole clock file)
  always_comb begin
    case (rx_byte[5:1])
      5'd0:    single_rd = sec_q;
      5'd1:    single_rd = min_q;
      5'd2:    single_rd = hour_q;
      5'd3:    single_rd = date_q;
      5'd4:    single_rd = month_q;
      5'd5:    single_rd = week_q;
      5'd6:    single_rd = year_q;
      5'd7:    single_rd = {wp_q, 7'd0};
      default: single_rd = 8'h00;
    endcase
    if (rx_byte[6]) single_rd = 8'h00;
    rd_snap = {56'd0, single_rd};
    if (is_burst)
      rd_snap = {wp_q, 7'd0, year_q, week_q, month_q, date_q, hour_q, min_q, sec_q};
  end

  // Decide whether the byte completing on this rise is committed, and where
  always_comb begin
    wr_en  = 1'b0;
    wr_idx = addr_q[2:0];
    if (state_q == S_WDATA && ce_s && sclk_rise && cnt_q[2:0] == 3'd7) begin
      if (burst_q) begin
        wr_idx = cnt_q[5:3];
        wr_en  = (cnt_q[5:3] == 3'd7) || !wp_lat_q;
      end else begin
        wr_en = !ram_q && (addr_q[4:3] == 2'b00) && ((addr_q[2:0] == 3'd7) || !wp_lat_q);
      end
    end
  end

  // Clock registers, prescaler and the serial transaction FSM
  always_ff @(posedge ds1302_clk) begin
    if (ds1302_rst) begin
      sec_q <= 8'h80; min_q <= 8'h00; hour_q <= 8'h00; date_q <= 8'h01;
      month_q <= 8'h01; week_q <= 8'h01; year_q <= 8'h00; wp_q <= 1'b0;
      presc_q <= '0;
      state_q <= S_IDLE; cnt_q <= 6'd0; shift_q <= 8'h00; addr_q <= 5'd0;
      ram_q <= 1'b0; burst_q <= 1'b0; wp_lat_q <= 1'b0;
      rd_buf_q <= 64'd0; rd_last_q <= 6'd7; rd_done_q <= 1'b0;
      io_oe_q <= 1'b0; io_out_q <= 1'b0;
      wr_commit_q <= 1'b0; sec_tick_q <= 1'b0;
    end else begin
      wr_commit_q <= wr_en;
      sec_tick_q  <= tick_fire;

      if (sec_q[7] || (wr_en && wr_idx == 3'd0) || tick_fire) presc_q <= '0;
      else                                                    presc_q <= presc_q + PW'(1);

      // Tick first; a write to the same register below overrides it
      if (tick_fire) begin
        sec_q <= {sec_q[7], sec_step[6:0]};
        if (sec_step[7]) begin
          min_q <= {min_q[7], min_step[6:0]};
          if (min_step[7]) hour_q <= {hour_q[7:6], hour_inc};
        end
      end
      if (wr_en) begin
        case (wr_idx)
          3'd0: sec_q   <= rx_byte;
          3'd1: min_q   <= rx_byte;
          3'd2: hour_q  <= rx_byte;
          3'd3: date_q  <= rx_byte;
          3'd4: month_q <= rx_byte;
          3'd5: week_q  <= rx_byte;
          3'd6: year_q  <= rx_byte;
          default: wp_q <= rx_byte[7];
        endcase
      end

      if (!ce_s) begin
        state_q <= S_IDLE;
        io_oe_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            state_q   <= S_CMD;
            cnt_q     <= 6'd0;
            rd_done_q <= 1'b0;
            io_oe_q   <= 1'b0;
          end
          S_CMD: begin
            if (sclk_rise) begin
              shift_q <= rx_byte;
              cnt_q   <= cnt_q + 6'd1;
              if (cnt_q == 6'd7) begin
                cnt_q     <= 6'd0;
                addr_q    <= rx_byte[5:1];
                ram_q     <= rx_byte[6];
                burst_q   <= is_burst;
                wp_lat_q  <= wp_q;
                rd_buf_q  <= rd_snap;
                rd_last_q <= is_burst ? 6'd63 : 6'd7;
                rd_done_q <= 1'b0;
                if (!rx_byte[7])     state_q <= S_IGNORE;
                else if (rx_byte[0]) state_q <= S_RDATA;
                else                 state_q <= S_WDATA;
              end
            end
          end
          S_WDATA: begin
            if (sclk_rise) begin
              shift_q <= rx_byte;
              cnt_q   <= cnt_q + 6'd1;
              if (cnt_q[2:0] == 3'd7 && (!burst_q || cnt_q == 6'd63)) state_q <= S_IGNORE;
            end
          end
          S_RDATA: begin
            if (sclk_fall) begin
              if (rd_done_q) begin
                io_oe_q <= 1'b0;
                state_q <= S_IGNORE;
              end else begin
                io_oe_q  <= 1'b1;
                io_out_q <= rd_buf_q[cnt_q];
                cnt_q    <= cnt_q + 6'd1;
                if (cnt_q == rd_last_q) rd_done_q <= 1'b1;
              end
            end
          end
          default: begin
            io_oe_q <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
